// File: rtl/maxnet_pkg.sv
// ============================================================================
// Module      : maxnet_pkg
// Description : Shared types and constants for the Maxnet feeder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maxnet_pkg;

   localparam int NUM_INPUTS    = 4;
   localparam int DEFAULT_WIDTH = 5;
   localparam int CNT_W         = $clog2(NUM_INPUTS);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_INPUTS - 1);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/maxnet_watchdog.sv
// ============================================================================
// Module      : maxnet_watchdog
// Description : Loadable down-counter with clear; flags expiry once armed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxnet_watchdog #(
   parameter int MAX_COUNT = 256,
   parameter int CW        = $clog2(MAX_COUNT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   input  logic          en,
   output logic          expired
);

   logic [CW-1:0] count_q, count_d;
   logic          armed_q, armed_d;

   always_comb begin
      count_d = count_q;
      armed_d = armed_q;
      if (clr) begin
         count_d = '0;
         armed_d = 1'b0;
      end else if (load) begin
         count_d = load_value;
         armed_d = 1'b1;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         armed_q <= 1'b0;
      end else begin
         count_q <= count_d;
         armed_q <= armed_d;
      end
   end

   assign expired = armed_q && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/maxnet_feeder.sv
// ============================================================================
// Module      : maxnet_feeder
// Description : Gathers four candidates, starts Maxnet, returns its result.
//               Optional WAIT watchdog enabled by defining LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxnet_feeder
   import maxnet_pkg::*;
#(
   parameter int WIDTH          = DEFAULT_WIDTH,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] X1,
   output logic [WIDTH-1:0] X2,
   output logic [WIDTH-1:0] X3,
   output logic [WIDTH-1:0] X4,
   output logic             start,
   input  logic             mx_done,
   input  logic [WIDTH-1:0] mx_result,
   output logic [WIDTH-1:0] out_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             timeout_err
);

   state_t                           state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [NUM_INPUTS-1:0][WIDTH-1:0] slot_q, slot_d;
   logic                             blank_q, blank_d;
   logic [WIDTH-1:0]                 result_q, result_d;
   logic                             tmo_err_q, tmo_err_d;
   logic                             w_accept;
   logic                             w_expired;

   // rst gates in_ready so nothing is offered while reset is held.
   assign in_ready = rst && (state_q == S_FILL);
   assign w_accept = in_valid && in_ready;

`ifdef LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

   maxnet_watchdog #(
      .MAX_COUNT (TIMEOUT_CYCLES),
      .CW        (TMO_W)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .clr        (state_q == S_FILL),
      .load       (state_q == S_START),
      .load_value (TMO_LOAD),
      .en         ((state_q == S_WAIT) && !w_expired),
      .expired    (w_expired)
   );
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
   assign w_expired    = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      slot_d    = slot_q;
      blank_d   = blank_q;
      result_d  = result_q;
      tmo_err_d = tmo_err_q;
      case (state_q)
         S_FILL: begin
            if (w_accept) begin
               slot_d[cnt_q] = in_data;
               cnt_d         = cnt_q + 1'b1;
               if (cnt_q == LAST_SLOT) begin
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            blank_d = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // First WAIT cycle is blanked so a stale done cannot be taken.
            blank_d = 1'b0;
            if (!blank_q && mx_done) begin
               result_d  = mx_result;
               tmo_err_d = 1'b0;
               state_d   = S_HOLD;
            end else if (w_expired) begin
               result_d  = '0;
               tmo_err_d = 1'b1;
               state_d   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               tmo_err_d = 1'b0;
               cnt_d     = '0;
               state_d   = S_FILL;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FILL;
         cnt_q     <= '0;
         slot_q    <= '0;
         blank_q   <= 1'b0;
         result_q  <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         slot_q    <= slot_d;
         blank_q   <= blank_d;
         result_q  <= result_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign X1          = slot_q[0];
   assign X2          = slot_q[1];
   assign X3          = slot_q[2];
   assign X4          = slot_q[3];
   assign start       = (state_q == S_START);
   assign busy        = (state_q == S_START) || (state_q == S_WAIT);
   assign out_valid   = (state_q == S_HOLD);
   assign out_result  = result_q;
   assign timeout_err = tmo_err_q;

endmodule

`default_nettype wire

// File: tb/tb_maxnet_feeder.sv
// ============================================================================
// Module      : tb_maxnet_feeder
// Description : Directed self-checking bench for maxnet_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxnet_feeder;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] X1, X2, X3, X4;
   logic         start;
   logic         mx_done;
   logic [W-1:0] mx_result;
   logic [W-1:0] out_result;
   logic         out_valid;
   logic         out_ready;
   logic         busy;
   logic         timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   maxnet_feeder #(
      .WIDTH          (W),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .X1          (X1),
      .X2          (X2),
      .X3          (X3),
      .X4          (X4),
      .start       (start),
      .mx_done     (mx_done),
      .mx_result   (mx_result),
      .out_result  (out_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   typedef struct {
      logic         iv;
      logic [W-1:0] d;
      logic         done;
      logic [W-1:0] res;
      logic         ordy;
      logic         e_ir;
      logic         e_start;
      logic         e_busy;
      logic         e_ov;
      logic [W-1:0] e_res;
      logic [4*W-1:0] e_x;
   } vec_t;

   vec_t tbl [10];

   function automatic vec_t mk(input logic iv, input logic [W-1:0] d,
                               input logic done, input logic [W-1:0] res,
                               input logic ordy, input logic e_ir,
                               input logic e_start, input logic e_busy,
                               input logic e_ov, input logic [W-1:0] e_res,
                               input logic [4*W-1:0] e_x);
      vec_t v;
      v.iv = iv; v.d = d; v.done = done; v.res = res; v.ordy = ordy;
      v.e_ir = e_ir; v.e_start = e_start; v.e_busy = e_busy; v.e_ov = e_ov;
      v.e_res = e_res; v.e_x = e_x;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [W-1:0] d, input logic done,
                        input logic [W-1:0] res, input logic ordy);
      in_valid  = iv;
      in_data   = d;
      mx_done   = done;
      mx_result = res;
      out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " in_ready"},  {31'd0, in_ready},  32'd0);
      check({tag, " X"},         {12'd0, X1, X2, X3, X4}, 32'd0);
      check({tag, " start"},     {31'd0, start},     32'd0);
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " out_result"}, {27'd0, out_result}, 32'd0);
      check({tag, " busy"},      {31'd0, busy},      32'd0);
      check({tag, " tmo_err"},   {31'd0, timeout_err}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global time limit expired");
      $fatal(1, "time limit");
   end

   initial begin
      logic [4*W-1:0] x1234;
      x1234 = {5'd1, 5'd2, 5'd3, 5'd4};
      tbl[0] = mk(1'b1, 5'd1,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, {5'd0, 5'd0, 5'd0, 5'd0});
      tbl[1] = mk(1'b1, 5'd2,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, {5'd1, 5'd0, 5'd0, 5'd0});
      tbl[2] = mk(1'b1, 5'd3,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, {5'd1, 5'd2, 5'd0, 5'd0});
      tbl[3] = mk(1'b1, 5'd4,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, {5'd1, 5'd2, 5'd3, 5'd0});
      tbl[4] = mk(1'b1, 5'd9,  1'b1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, x1234);
      tbl[5] = mk(1'b0, 5'd0,  1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, x1234);
      tbl[6] = mk(1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, x1234);
      tbl[7] = mk(1'b0, 5'd0,  1'b1, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, x1234);
      tbl[8] = mk(1'b0, 5'd0,  1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, x1234);
      tbl[9] = mk(1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, x1234);

      rst = 1'b0;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      #12;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Basic group, cycle by cycle
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].iv, tbl[i].d, tbl[i].done, tbl[i].res, tbl[i].ordy);
         #1;
         check($sformatf("row%0d in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
         check($sformatf("row%0d start", i),     {31'd0, start},     {31'd0, tbl[i].e_start});
         check($sformatf("row%0d busy", i),      {31'd0, busy},      {31'd0, tbl[i].e_busy});
         check($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
         check($sformatf("row%0d out_result", i), {27'd0, out_result}, {27'd0, tbl[i].e_res});
         check($sformatf("row%0d X", i),         {12'd0, X1, X2, X3, X4}, {12'd0, tbl[i].e_x});
         check($sformatf("row%0d tmo_err", i),   {31'd0, timeout_err}, 32'd0);
         @(posedge clk);
         #1;
      end

      // Gapped beats, done held high early, out_ready low for 5 cycles
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
      drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0); tick();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick(); tick();
      drive(1'b1, 5'd6, 1'b0, 5'd0, 1'b0); tick();
      drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0); tick();
      drive(1'b0, 5'd0, 1'b1, 5'd21, 1'b0); tick();
      check("gap partial X", {12'd0, X1, X2, X3, X4}, {12'd0, 5'd5, 5'd6, 5'd7, 5'd4});
      check("gap start low", {31'd0, start}, 32'd0);
      drive(1'b1, 5'd8, 1'b1, 5'd21, 1'b0); tick();
      check("gap start", {31'd0, start}, 32'd1);
      check("gap X", {12'd0, X1, X2, X3, X4}, {12'd0, 5'd5, 5'd6, 5'd7, 5'd8});
      drive(1'b1, 5'd30, 1'b1, 5'd21, 1'b0); tick();
      check("stale wait1 ov", {31'd0, out_valid}, 32'd0);
      tick();
      check("stale wait2 ov", {31'd0, out_valid}, 32'd0);
      check("stale wait2 busy", {31'd0, busy}, 32'd1);
      tick();
      check("stale capture ov", {31'd0, out_valid}, 32'd1);
      check("stale capture res", {27'd0, out_result}, 32'd21);
      drive(1'b1, 5'd30, 1'b1, 5'd3, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("hold%0d ov", k), {31'd0, out_valid}, 32'd1);
         check($sformatf("hold%0d res", k), {27'd0, out_result}, 32'd21);
         check($sformatf("hold%0d X1", k), {27'd0, X1}, 32'd5);
      end
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1); tick();
      check("hold release ov", {31'd0, out_valid}, 32'd0);
      check("hold release ir", {31'd0, in_ready}, 32'd1);

      // Maxnet returns 4 ten cycles after start, out_ready high
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, W'(2 * k + 2), 1'b0, 5'd0, 1'b1);
         tick();
      end
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      check("m10 start", {31'd0, start}, 32'd1);
      check("m10 ir", {31'd0, in_ready}, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("m10 c%0d start", k), {31'd0, start}, 32'd0);
         check($sformatf("m10 c%0d ov", k), {31'd0, out_valid}, 32'd0);
      end
      drive(1'b0, 5'd0, 1'b1, 5'd4, 1'b1); tick();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      check("m10 ov", {31'd0, out_valid}, 32'd1);
      check("m10 res", {27'd0, out_result}, 32'd4);
      check("m10 hold ir", {31'd0, in_ready}, 32'd0);
      tick();
      check("m10 ov clear", {31'd0, out_valid}, 32'd0);
      check("m10 ir back", {31'd0, in_ready}, 32'd1);

      // Reset after two beats, then again in WAIT
      drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0); tick();
      drive(1'b1, 5'd8, 1'b0, 5'd0, 1'b0); tick();
      check("pre-rst X", {12'd0, X1, X2, X3, X4}, {12'd0, 5'd7, 5'd8, 5'd6, 5'd8});
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("rst fill");
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b1, 5'd12, 1'b0, 5'd0, 1'b0); tick();
      drive(1'b1, 5'd13, 1'b0, 5'd0, 1'b0); tick();
      check("refill X", {12'd0, X1, X2, X3, X4}, {12'd0, 5'd12, 5'd13, 5'd0, 5'd0});
      drive(1'b1, 5'd14, 1'b0, 5'd0, 1'b0); tick();
      drive(1'b1, 5'd15, 1'b0, 5'd0, 1'b0); tick();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick(); tick();
      check("pre-rst wait busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("rst wait");
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("post-rst ir", {31'd0, in_ready}, 32'd1);

      for (int k = 0; k < 4; k++) begin
         drive(1'b1, W'(k + 1), 1'b0, 5'd0, 1'b0);
         tick();
      end
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
`ifdef LOADER_TIMEOUT_EN
      begin
         int n;
         n = 0;
         while (!out_valid && n < 100) begin
            tick();
            n++;
         end
         check("tmo latency", n, 32'd17);
         check("tmo ov", {31'd0, out_valid}, 32'd1);
         check("tmo res", {27'd0, out_result}, 32'd0);
         check("tmo err", {31'd0, timeout_err}, 32'd1);
         drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1); tick();
         check("tmo err clear", {31'd0, timeout_err}, 32'd0);
         check("tmo ov clear", {31'd0, out_valid}, 32'd0);
      end
`else
      for (int k = 0; k < 40; k++) tick();
      check("nowd ov", {31'd0, out_valid}, 32'd0);
      check("nowd busy", {31'd0, busy}, 32'd1);
      drive(1'b0, 5'd0, 1'b1, 5'd17, 1'b0); tick();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      check("nowd ov", {31'd0, out_valid}, 32'd1);
      check("nowd res", {27'd0, out_result}, 32'd17);
      check("nowd err", {31'd0, timeout_err}, 32'd0);
      tick();
      check("nowd ov clear", {31'd0, out_valid}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/maxnet_feeder.md
# maxnet_feeder

Sequencer that sits directly upstream of the Maxnet winner-take-all core. It collects four WIDTH-bit candidates from a valid/ready input stream and presents them on X1..X4. It then pulses start, waits for the core's done, and returns the core's result on a valid/ready output stream. One group is in flight at a time.

## Interface
- WIDTH, 5, bit width of every candidate and of the result
- TIMEOUT_CYCLES, 256, WAIT-state cycle limit; used only when LOADER_TIMEOUT_EN is defined
- clk  input  1  single system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- in_data  input  WIDTH  candidate value
- in_valid  input  1  in_data valid
- in_ready  output  1  feeder accepts in_data this cycle
- X1, X2, X3, X4  output  WIDTH each  candidates to Maxnet X1..X4
- start  output  1  one-cycle pulse to Maxnet start
- mx_done  input  1  Maxnet done
- mx_result  input  WIDTH  Maxnet result
- out_result  output  WIDTH  captured winner
- out_valid  output  1  out_result valid
- out_ready  input  1  downstream accepts out_result
- busy  output  1  high in START and WAIT
- timeout_err  output  1  current out_result came from a timeout

## Operation
- States: FILL, START, WAIT, HOLD. Reset state is FILL with the sample count at 0.
- Reset values: X1..X4=0, start=0, out_result=0, out_valid=0, busy=0, timeout_err=0. in_ready is forced to 0 while rst is low.
- FILL:
  - in_ready=1.
  - Each accepted beat (in_valid && in_ready at a rising edge) writes the next slot in order X1, X2, X3, X4. Count increments modulo 4.
  - Accepting the 4th beat moves the state to START.
- START:
  - start=1 for exactly this cycle. in_ready=0. mx_done is ignored.
  - Next state is WAIT.
- WAIT:
  - in_ready=0, busy=1.
  - mx_done is ignored in the first WAIT cycle (blanking for a stale done).
  - From the second WAIT cycle on, the first cycle with mx_done=1 captures mx_result into out_result and moves the state to HOLD.
- HOLD:
  - out_valid=1.
  - When out_valid && out_ready at an edge, out_valid clears, timeout_err clears, the state returns to FILL and the count resets to 0.
- X1..X4 change only on accepted beats in FILL. They are stable from START through the end of HOLD.
- mx_done and mx_result are ignored outside WAIT.
- in_valid outside FILL has no effect.
- No arithmetic is performed. Values pass through unmodified at WIDTH bits.

## Timing
- 4th beat accepted at edge N: start high during cycle N→N+1; WAIT begins at edge N+1.
- mx_done first sampled high in WAIT at edge M: out_valid is high from edge M onward, with out_result already valid.
- out_ready already high when out_valid rises: the handshake completes at the next edge and in_ready=1 the cycle after that.
- Minimum turnaround is 4 fill cycles + 1 START + 2 WAIT + 1 HOLD = 8 cycles per group.
- rst asserted in any state returns every output to its reset value immediately. A partial group or in-flight result is discarded. Operation resumes in FILL at the first edge after rst deasserts.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - A counter runs in WAIT, cleared on WAIT entry.
  - If it reaches TIMEOUT_CYCLES with no accepted mx_done, the state moves to HOLD with out_result=0 and timeout_err=1.
  - A done and a timeout in the same cycle resolve as done: timeout_err=0.
- LOADER_TIMEOUT_EN undefined:
  - No counter is built and WAIT is unbounded.
  - timeout_err is tied to 0.

## Structure
- Shared package maxnet_pkg holds:
  - the state enum typedef (FILL, START, WAIT, HOLD);
  - NUM_INPUTS=4;
  - the default WIDTH=5.
- One sub-module, maxnet_watchdog: a loadable down-counter with a clear input and an expired output. It is instantiated only under LOADER_TIMEOUT_EN.

## Test plan
- Reset then beats 1,2,3,4 → X1..X4=1,2,3,4; one start pulse one cycle after the 4th accept; in_ready=0 from START through HOLD.
- Maxnet model returns 4 with done 10 cycles after start, out_ready held high → out_result=4, out_valid high one cycle, in_ready=1 two cycles later.
- in_valid toggled with gaps, and out_ready held low 5 cycles → slot order preserved; out_valid and out_result stable until the handshake.
- mx_done held high before and during START and the first WAIT cycle → not captured early; capture occurs in the second WAIT cycle.
- rst asserted after 2 beats, and again in WAIT → all outputs return to reset values; the next group fills from X1.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no done → out_valid with out_result=0 and timeout_err=1; timeout_err clears after the handshake.
